// File: rtl/retire_arb_pkg.sv
// ---------------------------------------------------------------------------
// retire_arb_pkg
// Shared definitions for the retire arbiter: source count, FIFO depth,
// source ID constants, the retire record type, the arbiter FSM state type
// and the round-robin pick helper.
// ---------------------------------------------------------------------------
package retire_arb_pkg;

    localparam int NUM_SRC    = 6;
    localparam int FIFO_DEPTH = 2;

    localparam logic [2:0] SRC_SALU  = 3'd0;
    localparam logic [2:0] SRC_SIMD1 = 3'd1;
    localparam logic [2:0] SRC_SIMD2 = 3'd2;
    localparam logic [2:0] SRC_SIMD3 = 3'd3;
    localparam logic [2:0] SRC_SIMD4 = 3'd4;
    localparam logic [2:0] SRC_LSU   = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  wfid;
    } retire_rec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    // First requesting source found when scanning upward from ptr, wrapping
    // modulo NUM_SRC. Returns 0 when nothing requests (caller gates on that).
    function automatic logic [2:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                           input logic [2:0]         ptr);
        logic [2:0] pick;
        logic       found;
        logic [3:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NUM_SRC)) begin
                idx = idx - 4'(NUM_SRC);
            end
            if (!found && req[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/retire_fifo2.sv
// ---------------------------------------------------------------------------
// retire_fifo2
// Two-entry FIFO of retire records. A push while full is accepted only when a
// pop happens in the same cycle (the popped slot is reused). Pop on empty is
// ignored.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write strobe and record
//   pop             remove head record
//   full, empty     occupancy flags (registered)
//   head            oldest record (undefined when empty)
// ---------------------------------------------------------------------------
module retire_fifo2
    import retire_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  retire_rec_t push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output retire_rec_t head
);

    retire_rec_t r_mem [FIFO_DEPTH];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic w_pop;
    logic w_push;

    assign full   = (r_count == 2'(FIFO_DEPTH));
    assign empty  = (r_count == 2'd0);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign head   = r_mem[r_rd_ptr];

    // Storage has no reset: contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/retire_arbiter.sv
// ---------------------------------------------------------------------------
// retire_arbiter
// Serialises retire records from six sources (salu, simd1..4, lsu) into one
// trace stream. Each source buffers into its own 2-entry FIFO; a round-robin
// arbiter picks a non-empty FIFO and an IDLE/HOLD FSM freezes the grant while
// the consumer stalls.
// Optional feature macro: RETIRE_ARB_COUNT_EN adds retire_count, a wrapping
// 32-bit count of completed transfers.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   src_retire_valid[6]   per-source retire strobe
//   src_retire_pc[192]    6 x 32-bit PC, source i at [32i+31:32i]
//   src_wfid[36]          6 x 6-bit wavefront ID, source i at [6i+5:6i]
//   trace_valid/ready     output record handshake
//   trace_src/pc/wfid     presented record (zero when trace_valid is low)
//   retire_count          transfer count (RETIRE_ARB_COUNT_EN only)
//   src_overflow[6]       sticky per-source drop flags
// ---------------------------------------------------------------------------
module retire_arbiter
    import retire_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_retire_valid,
    input  logic [32*NUM_SRC-1:0] src_retire_pc,
    input  logic [6*NUM_SRC-1:0] src_wfid,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [2:0]           trace_src,
    output logic [31:0]          trace_pc,
    output logic [5:0]           trace_wfid,
`ifdef RETIRE_ARB_COUNT_EN
    output logic [31:0]          retire_count,
`endif
    output logic [NUM_SRC-1:0]   src_overflow
);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [2:0]         r_rr_ptr;
    logic [2:0]         w_rr_ptr_next;
    logic [2:0]         r_hold_src;
    logic [2:0]         w_hold_src_next;
    logic [NUM_SRC-1:0] r_overflow;

    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_pop;
    logic [NUM_SRC-1:0] w_drop;
    retire_rec_t        w_push_data [NUM_SRC];
    retire_rec_t        w_head      [NUM_SRC];

    logic [2:0] w_grant_idle;
    logic [2:0] w_grant;
    logic       w_valid;
    logic       w_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_push_data[gi] = '{pc:   src_retire_pc[32*gi +: 32],
                                       wfid: src_wfid[6*gi +: 6]};
            assign w_pop[gi]  = w_xfer && (w_grant == 3'(gi));
            // Drop only when full and this FIFO is not being drained now.
            assign w_drop[gi] = src_retire_valid[gi] && w_full[gi] && !w_pop[gi];

            retire_fifo2 u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (src_retire_valid[gi]),
                .push_data (w_push_data[gi]),
                .pop       (w_pop[gi]),
                .full      (w_full[gi]),
                .empty     (w_empty[gi]),
                .head      (w_head[gi])
            );
        end
    endgenerate

    // In HOLD the held FIFO cannot drain, so it stays non-empty and its head
    // stays put (pushes go behind it): the outputs are naturally frozen.
    assign w_grant_idle = rr_pick(~w_empty, r_rr_ptr);
    assign w_grant      = (r_state == ST_HOLD) ? r_hold_src : w_grant_idle;
    assign w_valid      = ~&w_empty;
    assign w_xfer       = w_valid && trace_ready;

    assign trace_valid  = w_valid;
    assign trace_src    = w_valid ? w_grant : 3'd0;
    assign trace_pc     = w_valid ? w_head[w_grant].pc   : 32'd0;
    assign trace_wfid   = w_valid ? w_head[w_grant].wfid : 6'd0;
    assign src_overflow = r_overflow;

    always_comb begin
        w_state_next    = r_state;
        w_rr_ptr_next   = r_rr_ptr;
        w_hold_src_next = r_hold_src;
        case (r_state)
            ST_IDLE: begin
                w_hold_src_next = w_grant_idle;
                if (w_valid && !trace_ready) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_xfer) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_xfer) begin
            w_rr_ptr_next = (w_grant == 3'(NUM_SRC - 1)) ? 3'd0 : w_grant + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= 3'd0;
            r_hold_src <= 3'd0;
            r_overflow <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_hold_src <= w_hold_src_next;
            r_overflow <= r_overflow | w_drop;
        end
    end

`ifdef RETIRE_ARB_COUNT_EN
    logic [31:0] r_retire_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_count <= 32'd0;
        end else if (w_xfer) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_retire_arbiter.sv
// ---------------------------------------------------------------------------
// tb_retire_arbiter
// Self-checking bench: a queue-style reference model (per-source record lists,
// round-robin pointer, hold flag) predicts the trace outputs every cycle.
// Directed scenarios plus a randomized phase.
// ---------------------------------------------------------------------------
module tb_retire_arbiter;
    import retire_arb_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   v   = '0;
    logic [191:0] pcs = '0;
    logic [35:0]  wfs = '0;
    logic         rdy = 1'b0;
    logic         trace_valid;
    logic [2:0]   trace_src;
    logic [31:0]  trace_pc;
    logic [5:0]   trace_wfid;
    logic [5:0]   src_overflow;
`ifdef RETIRE_ARB_COUNT_EN
    logic [31:0]  retire_count;
`endif

    always #5 clk = ~clk;

    retire_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .src_retire_valid (v),
        .src_retire_pc    (pcs),
        .src_wfid         (wfs),
        .trace_valid      (trace_valid),
        .trace_ready      (rdy),
        .trace_src        (trace_src),
        .trace_pc         (trace_pc),
        .trace_wfid       (trace_wfid),
`ifdef RETIRE_ARB_COUNT_EN
        .retire_count     (retire_count),
`endif
        .src_overflow     (src_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [37:0] m_q [6][2];   // {pc, wfid}, index 0 is oldest
    int          m_cnt [6];
    int          m_rr;
    bit          m_hold;
    int          m_hold_src;
    logic [5:0]  m_ovf;
    logic [31:0] m_count;
    bit          e_valid;
    int          e_src;

    task automatic m_clear();
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        m_rr = 0; m_hold = 0; m_hold_src = 0; m_ovf = '0; m_count = '0;
    endtask

    task automatic m_expect();
        e_valid = 0; e_src = 0;
        if (m_hold) begin
            e_valid = 1; e_src = m_hold_src;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (!e_valid && m_cnt[(m_rr + k) % 6] > 0) begin
                    e_valid = 1; e_src = (m_rr + k) % 6;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        m_expect();
        check("valid", trace_valid, e_valid);
        check("src",   trace_src,   e_valid ? e_src : 0);
        check("pc",    trace_pc,    e_valid ? m_q[e_src][0][37:6] : 0);
        check("wfid",  trace_wfid,  e_valid ? m_q[e_src][0][5:0]  : 0);
        check("ovf",   src_overflow, m_ovf);
`ifdef RETIRE_ARB_COUNT_EN
        check("count", retire_count, m_count);
`endif
    endtask

    // One clock: check present outputs, drive inputs, advance model at edge.
    task automatic cycle(input logic [5:0] vv, input logic [191:0] pp,
                         input logic [35:0] ww, input logic rr);
        compare_outputs();
        v = vv; pcs = pp; wfs = ww; rdy = rr;
        @(posedge clk);
        if (e_valid && rr) begin
            $display("[TB] xfer src=%0d pc=%08h wfid=%0d", e_src,
                     m_q[e_src][0][37:6], m_q[e_src][0][5:0]);
            m_q[e_src][0] = m_q[e_src][1];
            m_cnt[e_src]--;
            m_rr = (e_src + 1) % 6;
            m_hold = 0;
            m_count++;
        end else if (e_valid) begin
            m_hold = 1; m_hold_src = e_src;
        end
        for (int i = 0; i < 6; i++) begin
            if (vv[i]) begin
                if (m_cnt[i] < 2) begin
                    m_q[i][m_cnt[i]] = {pp[32*i +: 32], ww[6*i +: 6]};
                    m_cnt[i]++;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic rr);
        cycle(6'b0, '0, '0, rr);
    endtask

    task automatic push1(input int s, input logic [31:0] pc, input logic [5:0] wf,
                         input logic rr);
        logic [5:0]   vv;
        logic [191:0] pp;
        logic [35:0]  ww;
        vv = '0; pp = '0; ww = '0;
        vv[s] = 1'b1; pp[32*s +: 32] = pc; ww[6*s +: 6] = wf;
        cycle(vv, pp, ww, rr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v = '0; rdy = 1'b0;
        #1;
        check("rst_valid", trace_valid, 0);
        check("rst_src",   trace_src,   0);
        check("rst_pc",    trace_pc,    0);
        check("rst_wfid",  trace_wfid,  0);
        check("rst_ovf",   src_overflow, 0);
`ifdef RETIRE_ARB_COUNT_EN
        check("rst_count", retire_count, 0);
`endif
        m_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [191:0] pp;
        logic [35:0]  ww;
        logic [5:0]   vv;
        m_clear();
        @(posedge clk);
        do_reset();

        // Single salu record, visible one cycle after the push, for one cycle.
        push1(0, 32'h10, 6'd3, 1'b1);
        check("s1_valid", trace_valid, 1);
        check("s1_src",   trace_src,   0);
        check("s1_pc",    trace_pc,    32'h10);
        check("s1_wfid",  trace_wfid,  6'd3);
        idle(1'b1);
        check("s1_once",  trace_valid, 0);

        // All six sources at once: 0..5 in order.
        do_reset();
        pp = '0;
        for (int i = 0; i < 6; i++) pp[32*i +: 32] = 32'(i);
        cycle(6'b111111, pp, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check("all6_src", trace_src, i);
            idle(1'b1);
        end
        check("all6_ovf", src_overflow, 0);

        // Backpressure: simd3 held while lsu arrives.
        do_reset();
        push1(3, 32'h20, 6'd7, 1'b0);
        idle(1'b0);
        push1(5, 32'h55, 6'd9, 1'b0);
        idle(1'b0);
        check("bp_src", trace_src, 3);
        check("bp_pc",  trace_pc,  32'h20);
        idle(1'b1);
        check("bp_next", trace_src, 5);
        idle(1'b1);
        idle(1'b1);

        // Overflow: lsu 1,2,3 while stalled; 3 is lost.
        do_reset();
        push1(5, 32'd1, 6'd0, 1'b0);
        push1(5, 32'd2, 6'd0, 1'b0);
        push1(5, 32'd3, 6'd0, 1'b0);
        check("ovf_flag", src_overflow, 6'b100000);
        check("ovf_pc1",  trace_pc, 32'd1);
        idle(1'b1);
        check("ovf_pc2",  trace_pc, 32'd2);
        idle(1'b1);
        check("ovf_empty", trace_valid, 0);
        idle(1'b1);

        // Full FIFO push coinciding with pop: no drop, order A,B,C.
        do_reset();
        push1(1, 32'hA, 6'd1, 1'b0);
        push1(1, 32'hB, 6'd1, 1'b0);
        push1(1, 32'hC, 6'd1, 1'b1);
        check("fp_ovf", src_overflow, 0);
        check("fp_pcB", trace_pc, 32'hB);
        idle(1'b1);
        check("fp_pcC", trace_pc, 32'hC);
        idle(1'b1);
        idle(1'b1);

        // Reset with four buffered records.
        do_reset();
        cycle(6'b001111, '0, '0, 1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b0);
        idle(1'b0);
        check("rst_after", trace_valid, 0);

`ifdef RETIRE_ARB_COUNT_EN
        do_reset();
        cycle(6'b011111, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("cnt5", retire_count, 32'd5);
        do_reset();
`endif

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            vv = 6'($urandom & $urandom);
            for (int i = 0; i < 6; i++) begin
                pp[32*i +: 32] = $urandom;
                ww[6*i +: 6]   = 6'($urandom);
            end
            cycle(vv, pp, ww, ($urandom % 4) != 0);
        end
        for (int n = 0; n < 16; n++) idle(1'b1);
        compare_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
